// File: rtl/dvp_transmitter.sv
// dvp_transmitter: turns an upstream ready/valid pixel stream into a camera-style DVP stream.
//
// Parameters
//   H_ACTIVE     : pixel strobes per line with hsync high (1..8191)
//   H_BLANK      : strobes per line with hsync low (>=1)
//   V_ACTIVE     : lines per frame with vsync high (1..4095)
//   V_BLANK      : line-times with vsync low between frames (>=1)
//   PIXEL_PERIOD : clk cycles per pixel strobe (>=1)
//
// Ports
//   clk_in        : system clock, rising edge
//   rst_n_in      : asynchronous active-low reset
//   enable_in     : permits starting a new frame (sampled at IDLE exit and at end of frame)
//   valid_in      : upstream pixel available
//   pixel_in      : upstream pixel
//   ready_out     : accept strobe; transfer when ready_out && valid_in
//   valid_out     : one-cycle DVP pixel strobe, one per tick in every state
//   pixel_out     : DVP pixel data (zero during blanking and on underflow)
//   hsync_out     : high while the line is active
//   vsync_out     : high while the frame is active
//   underflow_out : sticky; set when an active pixel was needed but valid_in was low

module dvp_transmitter #(
    parameter int unsigned H_ACTIVE     = 1280,
    parameter int unsigned H_BLANK      = 8,
    parameter int unsigned V_ACTIVE     = 720,
    parameter int unsigned V_BLANK      = 2,
    parameter int unsigned PIXEL_PERIOD = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic        valid_in,
    input  logic [15:0] pixel_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [15:0] pixel_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        underflow_out
);

    localparam int unsigned DivW = (PIXEL_PERIOD > 1) ? $clog2(PIXEL_PERIOD) : 1;

    localparam logic [DivW-1:0] DivLast  = DivW'(PIXEL_PERIOD - 1);
    localparam logic [25:0]     VbLast   = 26'(V_BLANK * (H_ACTIVE + H_BLANK) - 1);
    localparam logic [12:0]     HActLast = 13'(H_ACTIVE - 1);
    localparam logic [12:0]     HBlkLast = 13'(H_BLANK - 1);
    localparam logic [11:0]     VActLast = 12'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StVblank,
        StActive,
        StHblank
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [12:0]     hcnt_q, hcnt_d;
    logic [11:0]     line_q, line_d;
    logic [25:0]     vb_q, vb_d;
    logic            valid_q, valid_d;
    logic [15:0]     pixel_q, pixel_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            underflow_q, underflow_d;
    logic            tick;

    // Free-running divider: sets the pclk rate regardless of FSM state.
    assign tick  = (div_q == DivLast);
    assign div_d = tick ? '0 : div_q + 1'b1;

    // Only registered state feeds ready_out, so upstream can never form a comb loop through it.
    assign ready_out = tick && (state_q == StActive);

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        line_d      = line_q;
        vb_d        = vb_q;
        valid_d     = 1'b0;
        pixel_d     = pixel_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        underflow_d = underflow_q;

        if (tick) begin
            // The strobe launched now describes the state this tick was spent in.
            valid_d = 1'b1;
            hsync_d = (state_q == StActive);
            vsync_d = (state_q == StActive) || (state_q == StHblank);
            pixel_d = 16'h0000;
            if (state_q == StActive) begin
                if (valid_in) begin
                    pixel_d = pixel_in;
                end else begin
                    underflow_d = 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (enable_in) begin
                        state_d = StVblank;
                        vb_d    = '0;
                    end
                end
                StVblank: begin
                    if (vb_q == VbLast) begin
                        state_d = StActive;
                        vb_d    = '0;
                        hcnt_d  = '0;
                        line_d  = '0;
                    end else begin
                        vb_d = vb_q + 26'd1;
                    end
                end
                StActive: begin
                    if (hcnt_q == HActLast) begin
                        state_d = StHblank;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + 13'd1;
                    end
                end
                StHblank: begin
                    if (hcnt_q == HBlkLast) begin
                        hcnt_d = '0;
                        if (line_q == VActLast) begin
                            // End of frame: the only point besides IDLE where enable matters.
                            line_d = '0;
                            if (enable_in) begin
                                state_d = StVblank;
                                vb_d    = '0;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            line_d  = line_q + 12'd1;
                            state_d = StActive;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 13'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            div_q       <= '0;
            hcnt_q      <= '0;
            line_q      <= '0;
            vb_q        <= '0;
            valid_q     <= 1'b0;
            pixel_q     <= 16'h0000;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hcnt_q      <= hcnt_d;
            line_q      <= line_d;
            vb_q        <= vb_d;
            valid_q     <= valid_d;
            pixel_q     <= pixel_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
        end
    end

    assign valid_out     = valid_q;
    assign pixel_out     = pixel_q;
    assign hsync_out     = hsync_q;
    assign vsync_out     = vsync_q;
    assign underflow_out = underflow_q;

endmodule

// File: tb/tb_dvp_transmitter.sv
// Directed bench: instance a uses PIXEL_PERIOD=1, instance b uses PIXEL_PERIOD=3,
// both with H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1 and shared inputs.
module tb_dvp_transmitter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        vin   = 1'b1;
    logic [15:0] pin   = 16'h0001;

    logic        rdy_a, vout_a, hs_a, vs_a, uf_a;
    logic [15:0] pout_a;
    logic        rdy_b, vout_b, hs_b, vs_b, uf_b;
    logic [15:0] pout_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic acc;

    always #5 clk = ~clk;

    dvp_transmitter #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1), .PIXEL_PERIOD(1)
    ) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .valid_in(vin), .pixel_in(pin),
        .ready_out(rdy_a), .valid_out(vout_a), .pixel_out(pout_a), .hsync_out(hs_a),
        .vsync_out(vs_a), .underflow_out(uf_a)
    );

    dvp_transmitter #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1), .PIXEL_PERIOD(3)
    ) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .valid_in(vin), .pixel_in(pin),
        .ready_out(rdy_b), .valid_out(vout_b), .pixel_out(pout_b), .hsync_out(hs_b),
        .vsync_out(vs_b), .underflow_out(uf_b)
    );

    // One clock cycle; pixel_in counts up whenever instance a accepted a pixel.
    task automatic tick_cycle();
        acc = rdy_a && vin;
        @(negedge clk);
        if (acc) pin = pin + 16'd1;
    endtask

    task automatic reset_dut(input logic en_v);
        rst_n = 1'b0;
        en    = en_v;
        vin   = 1'b1;
        pin   = 16'h0001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Expected {vsync, hsync, pixel} for strobe k after the initial IDLE strobe (24-strobe frame).
    function automatic logic [17:0] exp_basic(input int k);
        int j, jj, line, pos, base;
        j    = k % 24;
        base = 1 + 12 * (k / 24);
        if (j < 6) return 18'h0;
        jj   = j - 6;
        line = jj / 6;
        pos  = jj % 6;
        if (pos < 4) return {1'b1, 1'b1, 16'(base + line * 4 + pos)};
        return {1'b1, 1'b0, 16'h0000};
    endfunction

    // Whether tick number n (1 = first tick after reset) of instance b is spent in ACTIVE.
    function automatic logic b_active(input int n);
        int j;
        if (n < 2) return 1'b0;
        j = (n - 2) % 24;
        return (j >= 6) && (((j - 6) % 6) < 4);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rdy_a, vout_a, pout_a, hs_a, vs_a, uf_a} !== 21'h0)
            $display("FAIL reset_a: got %b required 0", {rdy_a, vout_a, pout_a, hs_a, vs_a, uf_a});
        n_tests++;
        if ({rdy_b, vout_b, pout_b, hs_b, vs_b, uf_b} !== 21'h0)
            $display("FAIL reset_b: got %b required 0", {rdy_b, vout_b, pout_b, hs_b, vs_b, uf_b});
        n_fail += ({rdy_a, vout_a, pout_a, hs_a, vs_a, uf_a} !== 21'h0) ? 1 : 0;
        n_fail += ({rdy_b, vout_b, pout_b, hs_b, vs_b, uf_b} !== 21'h0) ? 1 : 0;
    endtask

    task automatic test_basic();
        logic [17:0] e;
        reset_dut(1'b1);
        tick_cycle();
        n_tests++;
        if ({vout_a, vs_a, hs_a, pout_a} !== {1'b1, 18'h0}) begin
            n_fail++;
            $display("FAIL basic_idle_strobe: got %h required %h", {vout_a, vs_a, hs_a, pout_a},
                     {1'b1, 18'h0});
        end
        for (int k = 0; k < 48; k++) begin
            tick_cycle();
            e = exp_basic(k);
            n_tests++;
            if ({vout_a, vs_a, hs_a, pout_a} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL basic_strobe[%0d]: got v=%b vs=%b hs=%b px=%h required vs=%b hs=%b px=%h",
                         k, vout_a, vs_a, hs_a, pout_a, e[17], e[16], e[15:0]);
            end
        end
        n_tests++;
        if (uf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_underflow: got %b required 0", uf_a);
        end
    endtask

    task automatic test_underflow();
        logic [17:0] e;
        reset_dut(1'b1);
        tick_cycle();
        for (int k = 0; k < 30; k++) begin
            if (k == 13) vin = 1'b0;  // line 1, second active pixel
            tick_cycle();
            vin = 1'b1;
            e = exp_basic(k);
            if (k == 13) e[15:0] = 16'h0000;
            else if (k > 13 && e[16]) e[15:0] = e[15:0] - 16'd1;
            n_tests++;
            if ({vs_a, hs_a, pout_a, uf_a} !== {e, (k >= 13)}) begin
                n_fail++;
                $display("FAIL underflow_strobe[%0d]: got vs=%b hs=%b px=%h uf=%b required vs=%b hs=%b px=%h uf=%b",
                         k, vs_a, hs_a, pout_a, uf_a, e[17], e[16], e[15:0], (k >= 13));
            end
        end
    endtask

    task automatic test_divided();
        int   rise [2];
        int   n_rise;
        logic prev_vs;
        logic exp_rdy;
        int   diff;
        reset_dut(1'b1);
        n_rise  = 0;
        prev_vs = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            tick_cycle();
            n_tests++;
            if (vout_b !== ((c % 3) == 0)) begin
                n_fail++;
                $display("FAIL divided_valid[%0d]: got %b required %b", c, vout_b, ((c % 3) == 0));
            end
            exp_rdy = ((c % 3) == 2) && b_active((c + 1) / 3);
            n_tests++;
            if (rdy_b !== exp_rdy) begin
                n_fail++;
                $display("FAIL divided_ready[%0d]: got %b required %b", c, rdy_b, exp_rdy);
            end
            if (vs_b && !prev_vs && n_rise < 2) begin
                rise[n_rise] = c;
                n_rise++;
            end
            prev_vs = vs_b;
        end
        diff = (n_rise == 2) ? rise[1] - rise[0] : -1;
        n_tests++;
        if (diff != 72) begin
            n_fail++;
            $display("FAIL divided_frame_len: got %0d required 72", diff);
        end
    endtask

    task automatic test_enable_drop();
        logic [17:0] e;
        reset_dut(1'b1);
        tick_cycle();
        for (int k = 0; k < 24; k++) begin
            if (k == 8) en = 1'b0;  // mid line 0
            tick_cycle();
            e = exp_basic(k);
            n_tests++;
            if ({vout_a, vs_a, hs_a, pout_a} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL endrop_frame[%0d]: got v=%b vs=%b hs=%b px=%h required vs=%b hs=%b px=%h",
                         k, vout_a, vs_a, hs_a, pout_a, e[17], e[16], e[15:0]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick_cycle();
            n_tests++;
            if ({vout_a, vs_a, hs_a, pout_a, rdy_a} !== {1'b1, 19'h0}) begin
                n_fail++;
                $display("FAIL endrop_idle[%0d]: got v=%b vs=%b hs=%b px=%h rdy=%b required v=1 rest 0",
                         k, vout_a, vs_a, hs_a, pout_a, rdy_a);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick_cycle();
            n_tests++;
            if ({vout_a, vs_a, hs_a} !== 3'b100) begin
                n_fail++;
                $display("FAIL endrop_vblank[%0d]: got v=%b vs=%b hs=%b required v=1 vs=0 hs=0",
                         k, vout_a, vs_a, hs_a);
            end
        end
        tick_cycle();
        n_tests++;
        if ({vs_a, hs_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL endrop_restart: got vs=%b hs=%b required vs=1 hs=1", vs_a, hs_a);
        end
    endtask

    task automatic test_async_reset();
        reset_dut(1'b1);
        tick_cycle();
        for (int k = 0; k < 14; k++) begin
            vin = (k != 7);  // one underflow in line 0 so the sticky flag is set
            tick_cycle();
        end
        vin = 1'b1;
        n_tests++;
        if ({uf_a, hs_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL areset_pre: got uf=%b hs=%b required uf=1 hs=1", uf_a, hs_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rdy_a, vout_a, pout_a, hs_a, vs_a, uf_a} !== 21'h0) begin
            n_fail++;
            $display("FAIL areset_outputs: got %b required 0",
                     {rdy_a, vout_a, pout_a, hs_a, vs_a, uf_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick_cycle();
            n_tests++;
            if ({vout_a, vs_a, hs_a, pout_a} !== {1'b1, 18'h0}) begin
                n_fail++;
                $display("FAIL areset_vblank[%0d]: got v=%b vs=%b hs=%b px=%h required v=1 rest 0",
                         k, vout_a, vs_a, hs_a, pout_a);
            end
        end
        tick_cycle();
        n_tests++;
        if ({vs_a, hs_a, pout_a} !== {2'b11, pin - 16'd1}) begin
            n_fail++;
            $display("FAIL areset_first_pixel: got vs=%b hs=%b px=%h required vs=1 hs=1 px=%h",
                     vs_a, hs_a, pout_a, pin - 16'd1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_divided();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dvp_transmitter.md
# dvp_transmitter

Generates a camera-style DVP stream (valid strobe, 16-bit pixel, hsync, vsync) from an upstream ready/valid pixel source. It is the transmit end of the interface consumed by `dvp_receiver`. It serves as a synthetic camera for loopback tests and as a driver for downstream DVP sinks. Frame geometry and pixel-clock rate are set by parameters.

## Interface
- `H_ACTIVE`, default 1280: pixel strobes per line with hsync high (1..8191).
- `H_BLANK`, default 8: strobes per line with hsync low (>=1).
- `V_ACTIVE`, default 720: lines per frame with vsync high (1..4095).
- `V_BLANK`, default 2: line-times with vsync low between frames (>=1).
- `PIXEL_PERIOD`, default 1: clk cycles per pixel strobe (>=1).
- `clk_in` input 1: system clock; all logic is on the rising edge.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `enable_in` input 1: permits starting a new frame.
- `valid_in` input 1: upstream pixel available.
- `pixel_in` input 16: upstream pixel.
- `ready_out` output 1: accept strobe; a transfer occurs when `ready_out && valid_in`.
- `valid_out` output 1: one-cycle DVP pixel strobe.
- `pixel_out` output 16: DVP pixel data.
- `hsync_out` output 1: high while the line is active.
- `vsync_out` output 1: high while the frame is active.
- `underflow_out` output 1: sticky flag; set when an active pixel was needed but `valid_in` was low.

## Operation
- **Tick divider:** counts 0..PIXEL_PERIOD-1 and runs freely from reset. `tick` is true when the count equals PIXEL_PERIOD-1. With PIXEL_PERIOD=1, tick is true every cycle.
- **State changes:** the FSM and the h/v counters advance only on tick cycles.
- **FSM states:** IDLE, VBLANK, ACTIVE, HBLANK.
  - IDLE: vsync=0, hsync=0. On a tick with `enable_in`=1, go to VBLANK.
  - VBLANK: vsync=0, hsync=0. Lasts V_BLANK*(H_ACTIVE+H_BLANK) ticks, then goes to ACTIVE with line 0, pixel 0.
  - ACTIVE: vsync=1, hsync=1. Lasts H_ACTIVE ticks, then goes to HBLANK.
  - HBLANK: vsync=1, hsync=0. Lasts H_BLANK ticks. Then:
    - if this is not the last line, go to ACTIVE and increment the line count;
    - after line V_ACTIVE-1, go to VBLANK if `enable_in`=1, otherwise go to IDLE.
- **Enable sampling:** `enable_in` is sampled only at IDLE exit and at end of frame. Deasserting it mid-frame never truncates the frame.
- **ready_out:** equals `tick && state==ACTIVE`. It is driven combinationally from registered state only and never depends on `valid_in`.
- **Pixel selection** on each ACTIVE tick:
  - if a transfer occurs, the next `pixel_out` is `pixel_in`;
  - otherwise the next `pixel_out` is 16'h0000 and `underflow_out` sets.
- **Blanking pixels:** on VBLANK, HBLANK and IDLE ticks, `pixel_out` is 16'h0000.
- **Continuous strobe:** `valid_out` pulses on every tick in all states, including IDLE. This models a free-running pclk.
- **underflow_out:** clears only on reset.
- **Counters:** horizontal counter is 13 bits, line counter is 12 bits, VBLANK counter is 26 bits. No wrap occurs within legal parameter ranges.

## Timing
- **Reset values:** `valid_out`, `pixel_out`, `hsync_out`, `vsync_out`, `ready_out` and `underflow_out` are all 0. State is IDLE and all counters are 0. These take effect immediately on `rst_n_in` falling, independent of clk.
- **Output registers:** `valid_out`, `pixel_out`, `hsync_out` and `vsync_out` are registered.
  - They update on the clk edge that ends a tick cycle, with latency 1 from the tick cycle.
  - `valid_out` is 1 for exactly one cycle per tick.
  - `pixel_out`, `hsync_out` and `vsync_out` hold between strobes.
- **Strobe/flag alignment:** the hsync/vsync values presented with a strobe describe that strobe's pixel.
  - The first strobe of a line carries hsync=1.
  - The first strobe after the line's last active pixel carries hsync=0.
- **Handshake:** a pixel accepted at tick cycle t appears on `pixel_out` with `valid_out` in cycle t+1. Upstream sees at most one accept per PIXEL_PERIOD cycles.
- **Reset release:** the divider restarts at 0. With `enable_in`=1, the first tick leaves IDLE, so VBLANK strobes begin in the cycle after that tick.
- **Reset mid-frame:** all outputs return to reset values at once and no partial line completes. After release, the next frame begins with a full VBLANK.
- **Frame length:** a frame with continuous enable is (V_BLANK+V_ACTIVE)*(H_ACTIVE+H_BLANK)*PIXEL_PERIOD cycles.

## Test plan
- **Basic geometry.** Parameters H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, PIXEL_PERIOD=1. Stimulus: `enable_in`=1, `valid_in`=1 always, `pixel_in` counting from 16'h0001.
  - Required: 6 strobes with vsync=0, then 3 lines of 4 hsync=1 strobes (pixels 0001..000C) followed by 2 hsync=0 strobes.
  - The pattern repeats every 24 cycles; `underflow_out` stays 0.
- **Underflow.** Same parameters; drop `valid_in` for the 2nd active pixel of line 1.
  - Required: that strobe carries 16'h0000 with hsync=1, and `underflow_out`=1 from then until reset.
  - The line still has 4 active strobes.
- **Divided rate.** PIXEL_PERIOD=3.
  - Required: `valid_out` pulses exactly every 3rd cycle.
  - `ready_out` is high only in ACTIVE tick cycles; frame length is 72 cycles.
- **Enable drop.** Deassert `enable_in` in the middle of line 0.
  - Required: the frame completes all 3 lines, then vsync stays 0 in IDLE while `valid_out` keeps pulsing with 16'h0000.
  - Reasserting `enable_in` starts a VBLANK then a new frame.
- **Async reset.** Pulse `rst_n_in` low between clk edges in the middle of line 1.
  - Required: all outputs are 0 before the next edge.
  - After release, a full 6-strobe VBLANK precedes the first active pixel.
- **Loopback.** Connect to `dvp_receiver` with the basic-geometry parameters.
  - Required: the receiver's `valid_out` fires 12 times per frame with hcount 0..3 and vcount 0..2.
  - Received pixels match the sent pixels.
